if_stage: RTL and testbench

Instruction fetch stage: owns the program counter, issues word fetches to instruction memory and presents one instruction at a time to the decode stage. Once the downstream stages retire an instruction, it computes the next PC from the control flow results for that instruction (sequential, branch, jump, register jump) and fetches again. It sits between instruction memory and the decode stage; its `INSTRUCTION` output drives the decode stage's `instruction` input.

---
 rtl/if_pkg.sv | 28 ++
 rtl/if_stage_next_pc_calc.sv | 37 +++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Vectors are big-endian indexed [0:31]: bit 0 is the MSB.
package if_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } if_state_t;

  localparam logic [0:31] PC_INCR = 32'd4;

  // Instruction field boundaries
  localparam int OPC_HI = 0;
  localparam int OPC_LO = 5;
  localparam int JT_HI  = 6;
  localparam int JT_LO  = 31;
  localparam int IMM_HI = 16;
  localparam int IMM_LO = 31;

  // Sign-extended word offset of a 16-bit branch immediate.
  function automatic logic [0:31] branch_offset(input logic [0:15] imm);
    return {{14{imm[0]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_next_pc_calc.sv
// Combinational next-PC selection for the fetch stage: register jump,
// absolute jump, taken branch or sequential, in that priority.
import if_pkg::*;

module next_pc_calc (
  input  logic [0:31] pc,
  input  logic [0:31] instruction,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_use_reg,
  input  logic        branch_taken,
  input  logic [0:31] reg_target,
  output logic [0:31] next_pc,
  output logic        misaligned
);

  logic [0:31] pc_plus4;
  logic        unused_opcode;

  assign pc_plus4      = pc + PC_INCR;
  assign unused_opcode = ^instruction[OPC_HI:OPC_LO];

  always_comb begin
    next_pc = pc_plus4;
    if (jump && jump_use_reg) begin
      next_pc = reg_target;
    end else if (jump) begin
      // Absolute jump stays inside the 256 MiB region of the delay-free PC+4.
      next_pc = {pc_plus4[0:3], instruction[JT_HI:JT_LO], 2'b00};
    end else if (branch && branch_taken) begin
      next_pc = pc_plus4 + branch_offset(instruction[IMM_HI:IMM_LO]);
    end
  end

  assign misaligned = jump && jump_use_reg && (reg_target[30:31] != 2'b00);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word
// fetches and holds one instruction for decode until it is retired.
import if_pkg::*;

module if_stage #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMEM_REQ,
  output logic [0:31] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [0:31] IMEM_RDATA,
  output logic [0:31] INSTRUCTION,
  output logic        INSTR_VALID,
  output logic [0:31] PC,
  output logic [0:31] LINK_ADDR,
  input  logic        RETIRE,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JUMP_USE_REG,
  input  logic        BRANCH_TAKEN,
  input  logic [0:31] REG_TARGET,
  output logic        FETCH_ERR,
  output if_state_t   dbg_state
);

  // Handshakes: IMEM_REQ is a one-cycle pulse with IMEM_ADDR valid alongside;
  // IMEM_RVALID is honoured only in WAIT. INSTR_VALID acts as valid toward
  // decode and RETIRE as its ready/accept, honoured only in HOLD, so a RETIRE
  // held high consumes exactly one instruction per HOLD entry.
  if_state_t   state;
  if_state_t   next_state;
  logic [0:31] fetch_pc;
  logic [0:31] instr_q;
  logic [0:31] pc_q;
  logic [0:31] next_pc;
  logic        misaligned;

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .instruction  (instr_q),
    .branch       (BRANCH),
    .jump         (JUMP),
    .jump_use_reg (JUMP_USE_REG),
    .branch_taken (BRANCH_TAKEN),
    .reg_target   (REG_TARGET),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      instr_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      state <= next_state;
      if (state == WAIT && IMEM_RVALID) begin
        instr_q <= IMEM_RDATA;
        pc_q    <= fetch_pc;
      end
      if (state == HOLD && RETIRE && !misaligned) begin
        fetch_pc <= next_pc;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = REQ;
      REQ:  next_state = WAIT;
      WAIT: if (IMEM_RVALID) next_state = HOLD;
      HOLD: begin
        if (RETIRE) next_state = misaligned ? ERR : REQ;
      end
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  assign IMEM_REQ    = (state == REQ);
  assign IMEM_ADDR   = fetch_pc;
  assign INSTRUCTION = instr_q;
  assign INSTR_VALID = (state == HOLD);
  assign PC          = pc_q;
  assign LINK_ADDR   = pc_q + PC_INCR;
  assign FETCH_ERR   = (state == ERR);
  assign dbg_state   = state;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a 1-cycle instruction memory, a fetch
// address scoreboard, and one task per scenario.
import if_pkg::*;

module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic [31:0] PC;
  logic [31:0] LINK_ADDR;
  logic        RETIRE = 1'b0;
  logic        BRANCH = 1'b0;
  logic        JUMP = 1'b0;
  logic        JUMP_USE_REG = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] REG_TARGET = '0;
  logic        FETCH_ERR;
  if_state_t   dbg_state;

  logic        mem_auto = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] mem [logic [31:0]];

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  assign IMEM_RVALID = mem_auto ? mem_rvalid : man_rvalid;
  assign IMEM_RDATA  = mem_auto ? mem_rdata  : man_rdata;

  if_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .reset        (reset),
    .IMEM_REQ     (IMEM_REQ),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_RVALID  (IMEM_RVALID),
    .IMEM_RDATA   (IMEM_RDATA),
    .INSTRUCTION  (INSTRUCTION),
    .INSTR_VALID  (INSTR_VALID),
    .PC           (PC),
    .LINK_ADDR    (LINK_ADDR),
    .RETIRE       (RETIRE),
    .BRANCH       (BRANCH),
    .JUMP         (JUMP),
    .JUMP_USE_REG (JUMP_USE_REG),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .REG_TARGET   (REG_TARGET),
    .FETCH_ERR    (FETCH_ERR),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Memory with one cycle of latency; every request address is logged.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
      pend       = 1'b0;
    end
    if (IMEM_REQ === 1'b1) begin
      pend      = 1'b1;
      pend_addr = IMEM_ADDR;
      obs_q.push_back(IMEM_ADDR);
    end
  end

  // Driver tasks
  task automatic do_retire(input logic b, input logic j, input logic jr,
                           input logic bt, input logic [31:0] rt);
    BRANCH = b; JUMP = j; JUMP_USE_REG = jr; BRANCH_TAKEN = bt;
    REG_TARGET = rt; RETIRE = 1'b1;
    @(negedge clk);
    RETIRE = 1'b0; BRANCH = 1'b0; JUMP = 1'b0; JUMP_USE_REG = 1'b0;
    BRANCH_TAKEN = 1'b0; REG_TARGET = 32'hFFFF_FFFF;
  endtask

  task automatic wait_hold(input string name, output int cycles);
    cycles = 0;
    while (INSTR_VALID !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (INSTR_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_hold_timeout: INSTR_VALID=%b required 1", name, INSTR_VALID);
    end
  endtask

  // Scoreboard: compare each logged fetch address against the expected queue.
  task automatic drain_scoreboard(input string name);
    logic [31:0] e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_fetch_missing: no request seen, required addr %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s_fetch_addr: got %h required %h", name, o, e);
        end
      end
    end
  endtask

  task automatic jump_to(input logic [31:0] addr);
    int c;
    exp_q.push_back(addr);
    do_retire(1'b0, 1'b1, 1'b1, 1'b0, addr);
    wait_hold("jump_to", c);
    drain_scoreboard("jump_to");
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 7;
    if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", IMEM_REQ); end
    if (IMEM_ADDR !== 32'h100) begin n_fail++; $display("FAIL rst_addr: got %h required 00000100", IMEM_ADDR); end
    if (INSTRUCTION !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h required 0", INSTRUCTION); end
    if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", INSTR_VALID); end
    if (PC !== 32'h100) begin n_fail++; $display("FAIL rst_pc: got %h required 00000100", PC); end
    if (FETCH_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b required 0", FETCH_ERR); end
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d required IDLE", dbg_state); end
    exp_q.push_back(32'h100);
    reset = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (IMEM_REQ !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b required 1", IMEM_REQ); end
    if (IMEM_ADDR !== 32'h100) begin n_fail++; $display("FAIL first_addr: got %h required 00000100", IMEM_ADDR); end
    @(negedge clk);
    n_checks++;
    if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b required 0", INSTR_VALID); end
    @(negedge clk);
    n_checks += 4;
    if (INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b required 1", INSTR_VALID); end
    if (PC !== 32'h100) begin n_fail++; $display("FAIL first_pc: got %h required 00000100", PC); end
    if (LINK_ADDR !== 32'h104) begin n_fail++; $display("FAIL first_link: got %h required 00000104", LINK_ADDR); end
    if (INSTRUCTION !== 32'hA5A5_0001) begin n_fail++; $display("FAIL first_instr: got %h required a5a50001", INSTRUCTION); end
    drain_scoreboard("reset");
  endtask

  task automatic test_sequential();
    int c;
    logic [31:0] e;
    for (int i = 1; i <= 4; i++) begin
      e = 32'h100 + 32'(4 * i);
      exp_q.push_back(e);
      do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL seq_valid_drop: got %b required 0", INSTR_VALID); end
      wait_hold("seq", c);
      if (i == 1) begin
        n_checks++;
        if (c != 2) begin n_fail++; $display("FAIL seq_latency: got %0d cycles required 2", c); end
      end
      n_checks += 2;
      if (PC !== e) begin n_fail++; $display("FAIL seq_pc: got %h required %h", PC, e); end
      if (LINK_ADDR !== e + 32'd4) begin n_fail++; $display("FAIL seq_link: got %h required %h", LINK_ADDR, e + 32'd4); end
      drain_scoreboard("seq");
    end
  endtask

  task automatic test_branch();
    int c;
    mem[32'h200] = 32'h1000_FFFE;
    jump_to(32'h200);
    n_checks++;
    if (INSTRUCTION !== 32'h1000_FFFE) begin n_fail++; $display("FAIL br_instr: got %h required 1000fffe", INSTRUCTION); end
    exp_q.push_back(32'h1FC);
    do_retire(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0003);
    wait_hold("br_taken", c);
    drain_scoreboard("br_taken");
    n_checks++;
    if (PC !== 32'h1FC) begin n_fail++; $display("FAIL br_taken_pc: got %h required 000001fc", PC); end
    jump_to(32'h200);
    exp_q.push_back(32'h204);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_hold("br_not", c);
    drain_scoreboard("br_not");
    n_checks++;
    if (PC !== 32'h204) begin n_fail++; $display("FAIL br_not_pc: got %h required 00000204", PC); end
  endtask

  task automatic test_jump();
    int c;
    mem[32'h4000_0010] = 32'h0800_0040;
    jump_to(32'h4000_0010);
    exp_q.push_back(32'h4000_0100);
    // branch flags set too: jump must take priority; reg target unused
    do_retire(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0301);
    wait_hold("jmp", c);
    drain_scoreboard("jmp");
    n_checks += 2;
    if (PC !== 32'h4000_0100) begin n_fail++; $display("FAIL jmp_pc: got %h required 40000100", PC); end
    if (FETCH_ERR !== 1'b0) begin n_fail++; $display("FAIL jmp_err: got %b required 0", FETCH_ERR); end
    exp_q.push_back(32'h300);
    do_retire(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300);
    wait_hold("jr", c);
    drain_scoreboard("jr");
    n_checks++;
    if (PC !== 32'h300) begin n_fail++; $display("FAIL jr_pc: got %h required 00000300", PC); end
  endtask

  task automatic test_wrap();
    int c;
    jump_to(32'hFFFF_FFFC);
    n_checks++;
    if (LINK_ADDR !== 32'h0) begin n_fail++; $display("FAIL wrap_link: got %h required 00000000", LINK_ADDR); end
    exp_q.push_back(32'h0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_hold("wrap", c);
    drain_scoreboard("wrap");
    n_checks++;
    if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h required 00000000", PC); end
  endtask

  task automatic test_error();
    int c;
    int bad;
    do_retire(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0302);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      RETIRE = (i % 3 == 0);
      if (FETCH_ERR !== 1'b1 || INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b0) bad++;
      @(negedge clk);
    end
    RETIRE = 1'b0;
    n_checks += 3;
    if (bad != 0) begin n_fail++; $display("FAIL err_hold: %0d bad cycles required 0 (err=%b valid=%b req=%b)", bad, FETCH_ERR, INSTR_VALID, IMEM_REQ); end
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL err_no_req: %0d requests seen required 0", obs_q.size()); obs_q.delete(); end
    if (dbg_state !== ERR) begin n_fail++; $display("FAIL err_state: got %0d required ERR", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (FETCH_ERR !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", FETCH_ERR); end
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL err_reset_state: got %0d required IDLE", dbg_state); end
    exp_q.push_back(32'h100);
    reset = 1'b0;
    wait_hold("err_refetch", c);
    drain_scoreboard("err_refetch");
    n_checks++;
    if (PC !== 32'h100) begin n_fail++; $display("FAIL err_refetch_pc: got %h required 00000100", PC); end
  endtask

  task automatic test_reset_in_wait();
    mem_auto = 1'b0;
    exp_q.push_back(32'h104);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (dbg_state !== WAIT) begin n_fail++; $display("FAIL rw_in_wait: got %0d required WAIT", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'hBAD0_BAD0;
    exp_q.push_back(32'h100);
    @(negedge clk);
    n_checks += 2;
    if (dbg_state !== REQ) begin n_fail++; $display("FAIL rw_refetch_req: got %0d required REQ", dbg_state); end
    if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL rw_stale_valid: got %b required 0", INSTR_VALID); end
    RETIRE = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (dbg_state !== WAIT) begin n_fail++; $display("FAIL stray_req: got %0d required WAIT", dbg_state); end
    if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL stray_req_valid: got %b required 0", INSTR_VALID); end
    man_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== WAIT) begin n_fail++; $display("FAIL stray_wait: got %0d required WAIT", dbg_state); end
    RETIRE = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    n_checks += 3;
    if (dbg_state !== HOLD) begin n_fail++; $display("FAIL rw_hold: got %0d required HOLD", dbg_state); end
    if (INSTRUCTION !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_instr: got %h required deadbeef", INSTRUCTION); end
    if (PC !== 32'h100) begin n_fail++; $display("FAIL rw_pc: got %h required 00000100", PC); end
    drain_scoreboard("reset_wait");
    mem_auto = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    exp_q.push_back(32'h10C);
    RETIRE = 1'b1;
    repeat (9) @(negedge clk);
    RETIRE = 1'b0;
    n_checks += 2;
    if (INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b required 1", INSTR_VALID); end
    if (PC !== 32'h10C) begin n_fail++; $display("FAIL b2b_pc: got %h required 0000010c", PC); end
    @(negedge clk);
    n_checks++;
    if (dbg_state !== HOLD) begin n_fail++; $display("FAIL b2b_stays_hold: got %0d required HOLD", dbg_state); end
    drain_scoreboard("b2b");
  endtask

  initial begin
    mem[32'h100] = 32'hA5A5_0001;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_wrap();
    test_error();
    test_reset_in_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_exp_left: %0d entries required 0", exp_q.size()); end
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL sb_obs_extra: %0d entries required 0", obs_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
